// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the dmem_resp data-memory responder: FSM state
// encodings and the latency-counter width helper.
package dmem_resp_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Bits needed to hold LATENCY-1; never narrower than one bit.
  function automatic int cnt_width(input int latency);
    return (latency <= 2) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// Single-port DEPTH x XLEN word array with per-byte write enables and a
// registered read port that holds its last value when not enabled.
module dmem_resp_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic [XLEN/8-1:0]        we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset; clearing a RAM
  // would need a reset port per word and the contents are undefined anyway.
  always_ff @(posedge clk) begin
    for (int b = 0; b < XLEN/8; b++) begin
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: valid/ready request in, response after LATENCY
// cycles. Define DMEM_RESP_ERR_EN to flag out-of-range accesses via resp_err.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int             XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int             DEPTH     = 4096,
  parameter int             LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN/8-1:0] req_wstrb,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = XLEN/8;
  localparam int CNT_W  = cnt_width(LATENCY);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              wen_q, oob_q;
  logic [IDX_W-1:0]  idx_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [XLEN-1:0]   wdata_q;

  logic [XLEN-1:0]   req_off;
  logic [IDX_W-1:0]  req_idx;
  logic              req_oob;
  logic              addr_unused;

  assign req_off = req_addr - BASE_ADDR;
  assign req_idx = req_off[IDX_W+1:2];

`ifdef DMEM_RESP_ERR_EN
  assign req_oob     = |req_off[XLEN-1:IDX_W+2];
  assign addr_unused = ^req_off[1:0];
`else
  assign req_oob     = 1'b0;
  assign addr_unused = ^{req_off[XLEN-1:IDX_W+2], req_off[1:0]};
`endif

  logic accept, access;
  logic              cur_wen, cur_oob;
  logic [IDX_W-1:0]  cur_idx;
  logic [STRB_W-1:0] cur_wstrb;
  logic [XLEN-1:0]   cur_wdata;
  logic [XLEN-1:0]   ram_rdata;

  assign accept = (state_q == S_IDLE) && req_valid;

  // With LATENCY=1 the array is touched on the accept edge itself, so the
  // live request fields feed the RAM; otherwise the latched copy does.
  assign cur_wen   = (state_q == S_IDLE) ? req_wen   : wen_q;
  assign cur_oob   = (state_q == S_IDLE) ? req_oob   : oob_q;
  assign cur_idx   = (state_q == S_IDLE) ? req_idx   : idx_q;
  assign cur_wstrb = (state_q == S_IDLE) ? req_wstrb : wstrb_q;
  assign cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

  // Gated by rst_b so a reset on the would-be access edge drops the write.
  assign access = rst_b &&
                  ((accept && (LATENCY == 1)) ||
                   ((state_q == S_WAIT) && (cnt_q == CNT_W'(1))));

  dmem_resp_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .re    (access && !cur_wen && !cur_oob),
    .we    ((access && cur_wen && !cur_oob) ? cur_wstrb : '0),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // NOTE: state_d takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
      S_WAIT:  if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      oob_q   <= 1'b0;
      idx_q   <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= CNT_W'(LATENCY - 1);
        wen_q   <= req_wen;
        oob_q   <= req_oob;
        idx_q   <= req_idx;
        wstrb_q <= req_wstrb;
        wdata_q <= req_wdata;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid && oob_q;
  // The RAM read register holds across RESP, so masking it keeps rdata stable.
  assign resp_rdata = (resp_valid && !wen_q && !oob_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: two instances (LATENCY 1 and 4),
// directed cases plus random traffic against a word-array reference model.
module tb_dmem_resp;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
`ifdef DMEM_RESP_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wen    [2];
  logic [31:0] req_addr   [2];
  logic [3:0]  req_wstrb  [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int lat_of [2] = '{1, 4};
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_resp #(.XLEN(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_b(rst_b[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wstrb(req_wstrb[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  dmem_resp #(.XLEN(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst_b(rst_b[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wstrb(req_wstrb[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle_state(input int d, input string tag);
    check({tag, ".req_ready"},  32'(req_ready[d]),  32'd1);
    check({tag, ".resp_valid"}, 32'(resp_valid[d]), 32'd0);
    check({tag, ".resp_rdata"}, resp_rdata[d],      32'd0);
    check({tag, ".resp_err"},   32'(resp_err[d]),   32'd0);
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  task automatic xact(input int d, input logic wen, input logic [31:0] addr,
                      input logic [3:0] wstrb, input logic [31:0] wdata, input int stall,
                      input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int n;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".ready_in"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_wen[d]   = wen;
    req_addr[d]  = addr;
    req_wstrb[d] = wstrb;
    req_wdata[d] = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_wdata[d] = ~wdata;
    n = 1;
    while (!resp_valid[d] && n < 20) begin
      check({tag, ".busy_ready"}, 32'(req_ready[d]), 32'd0);
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(lat_of[d]));
    for (int i = 0; i < stall; i++) begin
      check({tag, ".stall_rdata"}, resp_rdata[d], exp_rdata);
      check({tag, ".stall_ready"}, 32'(req_ready[d]), 32'd0);
      @(negedge clk);
    end
    check({tag, ".rdata"}, resp_rdata[d], exp_rdata);
    check({tag, ".err"}, 32'(resp_err[d]), 32'(exp_err));
    check({tag, ".valid"}, 32'(resp_valid[d]), 32'd1);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check({tag, ".post_valid"}, 32'(resp_valid[d]), 32'd0);
    check({tag, ".post_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  logic [31:0] model [16];

  initial begin
    logic [31:0] addr, exp_d, wd;
    logic [3:0]  strb;
    logic        wen, wrap, oob;
    int          w;

    for (int d = 0; d < 2; d++) begin
      rst_b[d] = 1'b0; req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0;
      req_wstrb[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) rst_b[d] = 1'b1;
    idle_state(0, "reset1");
    idle_state(1, "reset4");

    // Full write then read back.
    xact(0, 1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, "wr_full");
    xact(0, 1'b0, 32'h8000_0010, 4'h0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, "rd_full");

    // Byte-lane write and no-op write.
    xact(0, 1'b1, 32'h8000_0020, 4'hF, 32'h1122_3344, 0, 32'h0, 1'b0, "wr_base");
    xact(0, 1'b1, 32'h8000_0020, 4'h2, 32'h0000_AA00, 0, 32'h0, 1'b0, "wr_lane1");
    xact(0, 1'b0, 32'h8000_0020, 4'h0, 32'h0, 0, 32'h1122_AA44, 1'b0, "rd_lane1");
    xact(0, 1'b1, 32'h8000_0020, 4'h0, 32'hFFFF_FFFF, 0, 32'h0, 1'b0, "wr_noop");
    xact(0, 1'b0, 32'h8000_0020, 4'h0, 32'h0, 0, 32'h1122_AA44, 1'b0, "rd_noop");

    // LATENCY=4 with a held-off response.
    xact(1, 1'b1, 32'h8000_0100, 4'hF, 32'h0BAD_CAFE, 0, 32'h0, 1'b0, "l4_wr");
    xact(1, 1'b0, 32'h8000_0100, 4'h0, 32'h0, 3, 32'h0BAD_CAFE, 1'b0, "l4_rd_stall");

    // Out-of-range access: error when checked, wrap to word 0 otherwise.
    xact(0, 1'b1, 32'h8000_0000, 4'hF, 32'h0102_0304, 0, 32'h0, 1'b0, "w0_init");
    xact(0, 1'b1, 32'h8000_4000, 4'hF, 32'hCAFE_F00D, 0, 32'h0, ERR, "oob_wr");
    xact(0, 1'b0, 32'h8000_4000, 4'h0, 32'h0, 1, ERR ? 32'h0 : 32'hCAFE_F00D, ERR, "oob_rd");
    xact(0, 1'b0, 32'h8000_0000, 4'h0, 32'h0, 0, ERR ? 32'h0102_0304 : 32'hCAFE_F00D,
         1'b0, "w0_rd");

    // Reset during WAIT of a write drops the write.
    xact(1, 1'b1, 32'h8000_0014, 4'hF, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, "rst_pre");
    req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0014;
    req_wstrb[1] = 4'hF; req_wdata[1] = 32'h5A5A_5A5A;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("rst_wait_ready", 32'(req_ready[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_b[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_b[1] = 1'b1;
    idle_state(1, "rst_mid");
    xact(1, 1'b0, 32'h8000_0014, 4'h0, 32'h0, 0, 32'hA5A5_A5A5, 1'b0, "rst_rd");

    // Random traffic over a 16-word window, with occasional wrapped addresses.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        model[i] = $urandom;
        xact(d, 1'b1, BASE + 32'(i * 4), 4'hF, model[i], 0, 32'h0, 1'b0, "rnd_pre");
      end
      for (int t = 0; t < 40; t++) begin
        wen  = 1'($urandom_range(0, 1));
        w    = $urandom_range(0, 15);
        wrap = ($urandom_range(0, 5) == 0);
        addr = BASE + 32'(w * 4) + (wrap ? 32'(DEPTH * 4) : 32'h0) + 32'($urandom_range(0, 3));
        strb = 4'($urandom_range(0, 15));
        wd   = $urandom;
        oob  = ERR && wrap;
        if (wen) begin
          xact(d, 1'b1, addr, strb, wd, $urandom_range(0, 2), 32'h0, oob, "rnd_wr");
          if (!oob) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[w][b*8 +: 8] = wd[b*8 +: 8];
          end
        end else begin
          exp_d = oob ? 32'h0 : model[w];
          xact(d, 1'b0, addr, 4'h0, 32'h0, $urandom_range(0, 2), exp_d, oob, "rnd_rd");
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
